// File: rtl/hovalaag_sequencer_pkg.sv
// Shared constants for the Hovalaag step sequencer: state codes, one-hot CPU
// phase selects, load phase count and wrapper status bit positions.
package hovalaag_sequencer_pkg;

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_FETCH = 4'd1;
   localparam logic [3:0] ST_LATCH = 4'd2;
   localparam logic [3:0] ST_LOAD  = 4'd3;
   localparam logic [3:0] ST_EXEC  = 4'd4;
   localparam logic [3:0] ST_RD_ST = 4'd5;
   localparam logic [3:0] ST_RD_PC = 4'd6;
   localparam logic [3:0] ST_RD_OL = 4'd7;
   localparam logic [3:0] ST_RD_OH = 4'd8;
   localparam logic [3:0] ST_POST  = 4'd9;
   localparam logic [3:0] ST_OWAIT = 4'd10;

   localparam int LOAD_PHASES = 9;

   localparam logic [9:0] CA_INSTR0 = 10'h001;
   localparam logic [9:0] CA_EXEC   = 10'h020;
   localparam logic [9:0] CA_IN1_LO = 10'h040;
   localparam logic [9:0] CA_IN1_HI = 10'h080;
   localparam logic [9:0] CA_IN2_LO = 10'h100;
   localparam logic [9:0] CA_IN2_HI = 10'h200;

   localparam int STAT_IN1_ADV = 0;
   localparam int STAT_IN2_ADV = 1;
   localparam int STAT_OUT1    = 2;
   localparam int STAT_OUT2    = 3;

   // Phases 0..3 load the input slices (bits 6..9), phases 4..8 the instruction slices (bits 0..4).
   function automatic logic [9:0] load_phase_addr(input logic [3:0] phase);
      if (phase < 4'd4) return CA_IN1_LO << phase;
      return CA_INSTR0 << (phase - 4'd4);
   endfunction

endpackage

// File: rtl/hovalaag_sequencer.sv
// Drives one Hovalaag CPU step per 17 cycles: fetch, load wrapper, exec, read back, pop/push streams.
// A pending output holds the sequencer in OWAIT until out_ready; run only gates the start of a step.
module hovalaag_sequencer
   import hovalaag_sequencer_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_run,
   output logic [7:0]  o_rom_addr,
   output logic        o_rom_en,
   input  logic [31:0] i_rom_data,
   input  logic [11:0] i_in1_data,
   input  logic        i_in1_valid,
   output logic        o_in1_ready,
   input  logic [11:0] i_in2_data,
   input  logic        i_in2_valid,
   output logic        o_in2_ready,
   output logic [11:0] o_out_data,
   output logic        o_out_sel,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [9:0]  o_cpu_addr,
   output logic [5:0]  o_cpu_in,
   input  logic [7:0]  i_cpu_out,
   output logic        o_busy,
   output logic        o_underflow,
   output logic [15:0] o_steps
);

   logic [3:0]  r_state;
   logic [3:0]  r_phase;
   logic [7:0]  r_pc;
   logic [7:0]  r_pc_new;
   logic [15:0] r_steps;
   logic [31:0] r_instr;
   logic [11:0] r_in1;
   logic [11:0] r_in2;
   logic [3:0]  r_status;
   logic [11:0] r_out;
   logic        r_out_sel;
   logic        r_underflow;

   logic [3:0]  w_state_nxt;
   logic [11:0] w_in1;
   logic [11:0] w_in2;
   logic        w_uf_now;
   logic        w_has_out;
   logic        w_step_done;
   logic        w_last_phase;

   assign w_in1        = i_in1_valid ? i_in1_data : 12'd0;
   assign w_in2        = i_in2_valid ? i_in2_data : 12'd0;
   assign w_has_out    = r_status[STAT_OUT1] | r_status[STAT_OUT2];
   assign w_last_phase = (r_phase == 4'(LOAD_PHASES - 1));
   assign w_uf_now     = (r_state == ST_POST) &&
                         ((r_status[STAT_IN1_ADV] && !i_in1_valid) ||
                          (r_status[STAT_IN2_ADV] && !i_in2_valid));
   assign w_step_done  = ((r_state == ST_POST) && !w_has_out) ||
                         ((r_state == ST_OWAIT) && i_out_ready);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (i_run && !r_underflow) w_state_nxt = ST_FETCH;
         ST_FETCH: w_state_nxt = ST_LATCH;
         ST_LATCH: w_state_nxt = ST_LOAD;
         ST_LOAD:  if (w_last_phase) w_state_nxt = ST_EXEC;
         ST_EXEC:  w_state_nxt = ST_RD_ST;
         ST_RD_ST: w_state_nxt = ST_RD_PC;
         ST_RD_PC: w_state_nxt = ST_RD_OL;
         ST_RD_OL: w_state_nxt = ST_RD_OH;
         ST_RD_OH: w_state_nxt = ST_POST;
         ST_POST:  if (w_has_out) w_state_nxt = ST_OWAIT;
         ST_OWAIT: ;
         default:  w_state_nxt = ST_IDLE;
      endcase
      // An underflow in this very POST must already block the restart.
      if (w_step_done)
         w_state_nxt = (i_run && !(r_underflow || w_uf_now)) ? ST_FETCH : ST_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_phase     <= 4'd0;
         r_pc        <= 8'd0;
         r_pc_new    <= 8'd0;
         r_steps     <= 16'd0;
         r_instr     <= 32'd0;
         r_in1       <= 12'd0;
         r_in2       <= 12'd0;
         r_status    <= 4'd0;
         r_out       <= 12'd0;
         r_out_sel   <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_LATCH: begin
               r_instr <= i_rom_data;
               r_phase <= 4'd0;
            end
            ST_LOAD: begin
               r_phase <= r_phase + 4'd1;
               if (r_phase == 4'd0) begin
                  r_in1 <= w_in1;
                  r_in2 <= w_in2;
               end
            end
            ST_RD_PC: r_status   <= i_cpu_out[3:0];
            ST_RD_OL: r_pc_new   <= i_cpu_out;
            ST_RD_OH: r_out[7:0] <= i_cpu_out;
            ST_POST: begin
               r_out[11:8] <= i_cpu_out[3:0];
               r_out_sel   <= !r_status[STAT_OUT1];
            end
            default: ;
         endcase
         if (w_uf_now) r_underflow <= 1'b1;
         if (w_step_done) begin
            r_steps <= r_steps + 16'd1;
            r_pc    <= r_pc_new;
         end
      end
   end

   // Read-back cycles re-drive the same input slice so the wrapper's input registers hold.
   always_comb begin
      o_cpu_addr = 10'd0;
      o_cpu_in   = 6'd0;
      case (r_state)
         ST_LOAD: begin
            o_cpu_addr = load_phase_addr(r_phase);
            case (r_phase)
               4'd0:    o_cpu_in = w_in1[5:0];
               4'd1:    o_cpu_in = r_in1[11:6];
               4'd2:    o_cpu_in = r_in2[5:0];
               4'd3:    o_cpu_in = r_in2[11:6];
               4'd4:    o_cpu_in = r_instr[5:0];
               4'd5:    o_cpu_in = r_instr[11:6];
               4'd6:    o_cpu_in = r_instr[17:12];
               4'd7:    o_cpu_in = r_instr[23:18];
               default: o_cpu_in = r_instr[29:24];
            endcase
         end
         ST_EXEC: begin
            o_cpu_addr = CA_EXEC;
            o_cpu_in   = {4'b0000, r_instr[31:30]};
         end
         ST_RD_ST: begin
            o_cpu_addr = CA_IN1_LO;
            o_cpu_in   = r_in1[5:0];
         end
         ST_RD_PC: begin
            o_cpu_addr = CA_IN1_HI;
            o_cpu_in   = r_in1[11:6];
         end
         ST_RD_OL: begin
            o_cpu_addr = CA_IN2_LO;
            o_cpu_in   = r_in2[5:0];
         end
         ST_RD_OH: begin
            o_cpu_addr = CA_IN2_HI;
            o_cpu_in   = r_in2[11:6];
         end
         default: ;
      endcase
   end

   assign o_rom_addr  = r_pc;
   assign o_rom_en    = (r_state == ST_FETCH);
   assign o_in1_ready = (r_state == ST_POST) && r_status[STAT_IN1_ADV] && i_in1_valid;
   assign o_in2_ready = (r_state == ST_POST) && r_status[STAT_IN2_ADV] && i_in2_valid;
   assign o_out_valid = (r_state == ST_OWAIT);
   assign o_out_data  = r_out;
   assign o_out_sel   = r_out_sel;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_underflow = r_underflow;
   assign o_steps     = r_steps;

endmodule

// File: tb/tb_hovalaag_sequencer.sv
// Bench for hovalaag_sequencer: directed step table plus random steps against a step-level model.
module tb_hovalaag_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [7:0]  rom_addr;
   logic        rom_en;
   logic [31:0] rom_data = 32'd0;
   logic [11:0] in1_data = 12'd0;
   logic        in1_valid = 1'b0;
   logic        in1_ready;
   logic [11:0] in2_data = 12'd0;
   logic        in2_valid = 1'b0;
   logic        in2_ready;
   logic [11:0] out_data;
   logic        out_sel;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [9:0]  cpu_addr;
   logic [5:0]  cpu_in;
   logic [7:0]  cpu_out = 8'd0;
   logic        busy;
   logic        underflow;
   logic [15:0] steps;

   always #5 clk = ~clk;

   hovalaag_sequencer dut (
      .i_clk(clk), .i_reset(reset), .i_run(run),
      .o_rom_addr(rom_addr), .o_rom_en(rom_en), .i_rom_data(rom_data),
      .i_in1_data(in1_data), .i_in1_valid(in1_valid), .o_in1_ready(in1_ready),
      .i_in2_data(in2_data), .i_in2_valid(in2_valid), .o_in2_ready(in2_ready),
      .o_out_data(out_data), .o_out_sel(out_sel), .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_cpu_addr(cpu_addr), .o_cpu_in(cpu_in), .i_cpu_out(cpu_out),
      .o_busy(busy), .o_underflow(underflow), .o_steps(steps)
   );

   // Instruction ROM with one cycle read latency.
   logic [31:0] rom [256];
   always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

   // CPU wrapper model: records what was written per phase bit, answers read-back one cycle later.
   logic [3:0]  wm_status = 4'd0;
   logic [7:0]  wm_pc = 8'd0;
   logic [11:0] wm_out = 12'd0;
   logic [5:0]  wm_in [4];
   logic [5:0]  wm_ins [5];
   logic [1:0]  wm_exec;
   always @(posedge clk) begin
      cpu_out <= 8'd0;
      if (cpu_addr[6]) begin cpu_out <= {4'd0, wm_status};    wm_in[0] <= cpu_in; end
      if (cpu_addr[7]) begin cpu_out <= wm_pc;                wm_in[1] <= cpu_in; end
      if (cpu_addr[8]) begin cpu_out <= wm_out[7:0];          wm_in[2] <= cpu_in; end
      if (cpu_addr[9]) begin cpu_out <= {4'd0, wm_out[11:8]}; wm_in[3] <= cpu_in; end
      for (int k = 0; k < 5; k++) if (cpu_addr[k]) wm_ins[k] <= cpu_in;
      if (cpu_addr[5]) wm_exec <= cpu_in[1:0];
   end

   typedef struct {
      logic [3:0]  status;
      logic [7:0]  npc;
      logic [11:0] outv;
      logic        v1;
      logic [11:0] d1;
      logic        v2;
      logic [11:0] d2;
      logic [31:0] instr;
      int          stall;
      logic        drop_run;
      logic        rst_owait;
      logic        e_r1;
      logic        e_r2;
      logic        e_ovld;
      logic        e_osel;
      logic        e_uf;
   } step_t;

   int checks = 0;
   int failures = 0;
   logic [7:0]  exp_pc = 8'd0;
   logic [15:0] exp_steps = 16'd0;
   logic        exp_uf = 1'b0;
   logic [9:0]  exp_seq [14] = '{10'h040, 10'h080, 10'h100, 10'h200, 10'h001, 10'h002, 10'h004,
                                 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100, 10'h200};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic step_t ref_expect(input step_t s);
      step_t r;
      r = s;
      r.e_r1   = s.status[0] & s.v1;
      r.e_r2   = s.status[1] & s.v2;
      r.e_uf   = (s.status[0] & ~s.v1) | (s.status[1] & ~s.v2);
      r.e_ovld = s.status[2] | s.status[3];
      r.e_osel = ~s.status[2];
      return r;
   endfunction

   task automatic model_reset();
      exp_pc = 8'd0; exp_steps = 16'd0; exp_uf = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_cpu_addr", cpu_addr, 0);
      chk("rst_cpu_in", cpu_in, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_ready", {in1_ready, in2_ready}, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", {out_sel, out_data}, 0);
      chk("rst_steps", steps, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_rom_addr", rom_addr, 0);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic wait_fetch(input string name);
      int n;
      n = 0;
      while (!rom_en && n < 40) begin @(negedge clk); n++; end
      chk(name, rom_en, 1);
   endtask

   task automatic do_step(input step_t s);
      int rdy1, rdy2, n;
      logic [15:0] steps0;
      logic [11:0] e_in1, e_in2;
      wm_status = s.status; wm_pc = s.npc; wm_out = s.outv;
      rom[exp_pc] = s.instr;
      in1_valid = s.v1; in1_data = s.d1;
      in2_valid = s.v2; in2_data = s.d2;
      out_ready = 1'b0;
      e_in1 = s.v1 ? s.d1 : 12'd0;
      e_in2 = s.v2 ? s.d2 : 12'd0;
      wait_fetch("fetch_start");
      if (!rom_en) return;
      chk("fetch_rom_addr", rom_addr, exp_pc);
      chk("fetch_busy", busy, 1);
      rdy1 = 0; rdy2 = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 5) begin
            in1_data = ~s.d1;
            in2_data = ~s.d2;
            if (s.drop_run) run = 1'b0;
         end
         if (c >= 2 && c <= 15) chk("cpu_addr_seq", cpu_addr, exp_seq[c-2]);
         rdy1 += int'(in1_ready);
         rdy2 += int'(in2_ready);
      end
      chk("post_in1_ready", in1_ready, s.e_r1);
      chk("post_in2_ready", in2_ready, s.e_r2);
      chk("in_ready_pulses", {rdy1[7:0], rdy2[7:0]}, {7'd0, s.e_r1, 7'd0, s.e_r2});
      chk("wrapper_in1", {wm_in[1], wm_in[0]}, e_in1);
      chk("wrapper_in2", {wm_in[3], wm_in[2]}, e_in2);
      chk("wrapper_instr", {wm_exec, wm_ins[4], wm_ins[3], wm_ins[2], wm_ins[1], wm_ins[0]}, s.instr);
      steps0 = exp_steps;
      if (s.e_ovld) begin
         for (int k = 0; k <= s.stall; k++) begin
            @(negedge clk);
            chk("out_valid_hold", out_valid, 1);
            chk("steps_hold", steps, steps0);
            if (k == 0) begin
               chk("out_data", out_data, s.outv);
               chk("out_sel", out_sel, s.e_osel);
            end
            if (s.rst_owait && k == 1) begin
               reset = 1'b1;
               @(negedge clk);
               chk("rst_owait_valid", out_valid, 0);
               chk("rst_owait_busy", busy, 0);
               chk("rst_owait_steps", steps, 0);
               reset = 1'b0;
               model_reset();
               return;
            end
            if (k == s.stall) out_ready = 1'b1;
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
      exp_steps = exp_steps + 16'd1;
      exp_pc = s.npc;
      exp_uf = exp_uf | s.e_uf;
      chk("steps_after", steps, exp_steps);
      chk("out_valid_after", out_valid, 0);
      chk("underflow_after", underflow, exp_uf);
      if (exp_uf || s.drop_run) chk("idle_after_step", busy, 0);
      if (s.drop_run) run = 1'b1;
      if (exp_uf) begin
         n = 0;
         repeat (6) begin @(negedge clk); n += int'(rom_en | busy); end
         chk("no_restart", n, 0);
         chk("idle_rom_addr", rom_addr, exp_pc);
      end
   endtask

   task automatic reset_in_load();
      wait_fetch("rl_fetch");
      chk("rl_pc_before", rom_addr, exp_pc);
      repeat (6) @(negedge clk);
      chk("rl_phase4_addr", cpu_addr, 10'h001);
      reset = 1'b1;
      @(negedge clk);
      chk("rl_cpu_addr", cpu_addr, 0);
      chk("rl_busy", busy, 0);
      chk("rl_pc", rom_addr, 0);
      reset = 1'b0;
      model_reset();
   endtask

   step_t tbl [7];

   initial begin
      tbl[0] = '{4'h1, 8'h05, 12'h000, 1'b1, 12'h5A3, 1'b0, 12'h111, 32'h0000_0000, 0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{4'h4, 8'h06, 12'hABC, 1'b0, 12'h000, 1'b0, 12'h000, 32'hC123_4567, 5, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{4'hC, 8'h07, 12'h123, 1'b1, 12'h2B4, 1'b1, 12'h9C1, 32'h89AB_CDEF, 1, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{4'h8, 8'hFF, 12'h7E5, 1'b0, 12'h000, 1'b1, 12'hFED, 32'h3FFF_FFFF, 0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{4'h3, 8'h42, 12'h000, 1'b1, 12'hFFF, 1'b1, 12'h001, 32'h5555_AAAA, 0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{4'h2, 8'h10, 12'h000, 1'b1, 12'h0F0, 1'b0, 12'h777, 32'h0000_0001, 0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{4'h4, 8'h20, 12'h456, 1'b0, 12'h000, 1'b0, 12'h000, 32'h0000_0002, 4, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      apply_reset();
      run = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i == 5) reset_in_load();
         do_step(tbl[i]);
         if (exp_uf) apply_reset();
      end

      for (int i = 0; i < 40; i++) begin
         step_t s;
         s.status    = 4'($urandom_range(0, 15));
         s.npc       = 8'($urandom);
         s.outv      = 12'($urandom);
         s.v1        = ($urandom_range(0, 7) != 0);
         s.d1        = 12'($urandom);
         s.v2        = ($urandom_range(0, 7) != 0);
         s.d2        = 12'($urandom);
         s.instr     = $urandom;
         s.stall     = int'($urandom_range(0, 3));
         s.drop_run  = 1'b0;
         s.rst_owait = 1'b0;
         s = ref_expect(s);
         do_step(s);
         if (exp_uf) apply_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule
